// File: rtl/serdes_pkg.sv
// Shared definitions for the PISO/SIPO serial link; both ends import this
// so they agree on word width, bit order and state encoding.
package serdes_pkg;

  localparam int DW_DEFAULT        = 4;
  localparam bit MSB_FIRST_DEFAULT = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/sipo_shreg.sv
// Enabled shift register. `start` restarts the word so the incoming bit
// becomes bit 0. `word` is the contents including this cycle's bit.
module sipo_shreg #(
  parameter int W         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         start,
  input  logic         d,
  output logic [W-1:0] word
);

  logic [W-1:0] sh_q;
  logic [W-1:0] sh_d;

  generate
    if (W == 1) begin : g_w1
      always_comb begin
        sh_d = sh_q;
        if (en || start) sh_d = d;
      end
    end else if (MSB_FIRST) begin : g_msb
      // Bits enter at index 0 and move up; bit 0 ends at W-1.
      always_comb begin
        sh_d = sh_q;
        if (en) begin
          if (start) sh_d = {{(W-1){1'b0}}, d};
          else       sh_d = {sh_q[W-2:0], d};
        end
      end
    end else begin : g_lsb
      // Bits enter at index W-1 and move down; bit 0 ends at index 0.
      always_comb begin
        sh_d = sh_q;
        if (en) begin
          if (start) sh_d = {d, {(W-1){1'b0}}};
          else       sh_d = {d, sh_q[W-1:1]};
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sh_q <= '0;
    else     sh_q <= sh_d;
  end

  assign word = sh_d;

endmodule

// File: rtl/sipo_rx.sv
// Serial-in parallel-out receiver: sync-framed bits are assembled into
// DW-bit words and held in a one-entry valid/ready output register.
module sipo_rx
  import serdes_pkg::*;
#(
  parameter int DW        = DW_DEFAULT,
  parameter bit MSB_FIRST = MSB_FIRST_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  input  logic          s_in,
  input  logic          sync,
  output logic [DW-1:0] data_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          overrun,
  output logic          frame_err,
  output logic          dbg_state
);

  localparam int CW = $clog2(DW + 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] data_q;
  logic          valid_q;
  logic          overrun_q;
  logic          frame_err_q;

  logic          start;
  logic          shift_en;
  logic          complete;
  logic [CW-1:0] cnt_d;
  logic [DW-1:0] word;

  // A sync restarts the word in any state; plain bits only count while
  // a word is open.
  assign start    = s_valid && sync;
  assign shift_en = s_valid && (sync || (state_q == SHIFT));
  assign cnt_d    = sync ? CW'(1) : cnt_q + CW'(1);
  assign complete = shift_en && (cnt_d == CW'(DW));

  sipo_shreg #(
    .W         (DW),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .en    (shift_en),
    .start (start),
    .d     (s_in),
    .word  (word)
  );

  // Output handshake: a word transfers on any edge where out_valid and
  // out_ready are both 1. out_valid is purely registered, and a pop and a
  // new load on the same edge keep out_valid high with the new word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= start && (state_q == SHIFT);
      if (shift_en) begin
        if (complete) begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end else begin
          state_q <= SHIFT;
          cnt_q   <= cnt_d;
        end
      end
      if (complete) begin
        if (!valid_q || out_ready) begin
          data_q  <= word;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data_out  = data_q;
  assign out_valid = valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;
  assign dbg_state = logic'(state_q);

endmodule
